// File: rtl/traffic_lamp_sequencer.sv
// Checks the upstream phase-code ring, drives registered lamps, counts completed cycles, and flashes yellow on a fault.
// Optional build macro TLS_AUTO_RECOVER_EN: a 0000 code seen while in FAULT returns the block to SYNC.
module traffic_lamp_sequencer #(
  parameter int CNT_W     = 8,
  parameter int BLINK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       q_in,
  output logic             red,
  output logic             yellow,
  output logic             green,
  output logic             fault,
  output logic [CNT_W-1:0] cycle_cnt
);

  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  // Lamp vectors are packed as {red, yellow, green}
  localparam logic [2:0] LAMP_RED  = 3'b100;
  localparam logic [2:0] LAMP_RY   = 3'b110;
  localparam logic [2:0] LAMP_GRN  = 3'b001;
  localparam logic [2:0] LAMP_YEL  = 3'b010;

  typedef enum logic [1:0] {
    ST_SYNC  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [3:0]       q_prev_r, q_prev_s;
  logic [BLK_W-1:0] blk_r, blk_s;
  logic [2:0]       lamps_r, lamps_s;
  logic             fault_r, fault_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             step_ok_s;
  logic             wrap_s;
  logic [BLK_W-1:0] blk_adv_s;
  logic             yel_adv_s;

  function automatic logic is_legal(input logic [3:0] q);
    case (q)
      4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110: is_legal = 1'b1;
      default:                                               is_legal = 1'b0;
    endcase
  endfunction

  // The default is unreachable because q_prev only ever holds ring codes
  function automatic logic [3:0] succ(input logic [3:0] q);
    case (q)
      4'b0000: succ = 4'b0001;
      4'b0001: succ = 4'b0011;
      4'b0011: succ = 4'b0111;
      4'b0111: succ = 4'b1111;
      4'b1111: succ = 4'b1110;
      4'b1110: succ = 4'b0000;
      default: succ = 4'b0101;
    endcase
  endfunction

  function automatic logic [2:0] dec(input logic [3:0] q);
    case (q)
      4'b0000:          dec = LAMP_RED;
      4'b0001:          dec = LAMP_RY;
      4'b0011, 4'b0111: dec = LAMP_GRN;
      4'b1111, 4'b1110: dec = LAMP_YEL;
      default:          dec = LAMP_YEL;
    endcase
  endfunction

  // Step qualification and the free-running flash divider used in FAULT
  always_comb begin
    step_ok_s = is_legal(q_in) && (q_in == succ(q_prev_r));
    wrap_s    = (q_prev_r == 4'b1110) && (q_in == 4'b0000);
    if (blk_r == BLK_LAST) begin
      blk_adv_s = {BLK_W{1'b0}};
      yel_adv_s = ~lamps_r[1];
    end else begin
      blk_adv_s = blk_r + BLK_W'(1);
      yel_adv_s = lamps_r[1];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s  = state_r;
    q_prev_s = q_prev_r;
    blk_s    = blk_r;
    lamps_s  = lamps_r;
    fault_s  = fault_r;
    cnt_s    = cnt_r;
    case (state_r)
      ST_SYNC: begin
        lamps_s = LAMP_RED;
        fault_s = 1'b0;
        blk_s   = {BLK_W{1'b0}};
        if (q_in == 4'b0000) begin
          state_s  = ST_RUN;
          q_prev_s = 4'b0000;
          lamps_s  = dec(4'b0000);
        end else begin
          state_s  = ST_SYNC;
        end
      end
      ST_RUN: begin
        if (step_ok_s) begin
          q_prev_s = q_in;
          lamps_s  = dec(q_in);
          if (wrap_s && (cnt_r != CNT_MAX)) begin
            cnt_s = cnt_r + CNT_W'(1);
          end else begin
            cnt_s = cnt_r;
          end
        end else begin
          state_s = ST_FAULT;
          fault_s = 1'b1;
          lamps_s = LAMP_YEL;
          blk_s   = {BLK_W{1'b0}};
        end
      end
      ST_FAULT: begin
`ifdef TLS_AUTO_RECOVER_EN
        if (q_in == 4'b0000) begin
          state_s = ST_SYNC;
          fault_s = 1'b0;
          lamps_s = LAMP_RED;
          blk_s   = {BLK_W{1'b0}};
        end else begin
          fault_s = 1'b1;
          blk_s   = blk_adv_s;
          lamps_s = {1'b0, yel_adv_s, 1'b0};
        end
`else
        fault_s = 1'b1;
        blk_s   = blk_adv_s;
        lamps_s = {1'b0, yel_adv_s, 1'b0};
`endif
      end
      default: begin
        // A corrupted state encoding is treated as a fault
        state_s = ST_FAULT;
        fault_s = 1'b1;
        lamps_s = LAMP_YEL;
        blk_s   = {BLK_W{1'b0}};
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_SYNC;
      q_prev_r <= 4'b0000;
      blk_r    <= {BLK_W{1'b0}};
      lamps_r  <= LAMP_RED;
      fault_r  <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_s;
      q_prev_r <= q_prev_s;
      blk_r    <= blk_s;
      lamps_r  <= lamps_s;
      fault_r  <= fault_s;
      cnt_r    <= cnt_s;
    end
  end

  assign red       = lamps_r[2];
  assign yellow    = lamps_r[1];
  assign green     = lamps_r[0];
  assign fault     = fault_r;
  assign cycle_cnt = cnt_r;

endmodule
